// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit async-SRAM responder.
// Defines the init FSM state type, byte-lane slice bounds and the legal read-latency range.
// Also provides a helper that expands the two lane enables into a 16-bit data mask.
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        DONE = 1'b1
    } state_e;

    // Byte-lane bit ranges within a 16-bit half-word
    localparam int LANE_LO_LSB = 0;
    localparam int LANE_LO_MSB = 7;
    localparam int LANE_HI_LSB = 8;
    localparam int LANE_HI_MSB = 15;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // en[1] = upper lane enabled, en[0] = lower lane enabled (active high)
    function automatic logic [15:0] lane_mask(input logic [1:0] en);
        logic [15:0] m;
        m = '0;
        m[LANE_HI_MSB:LANE_HI_LSB] = {8{en[1]}};
        m[LANE_LO_MSB:LANE_LO_LSB] = {8{en[0]}};
        return m;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: delays {valid, word, lane enables} by RD_LAT cycles.
// Latency RD_LAT cycles from an accepted read to the data_oe pulse; one read per cycle.
// No backpressure: the bus master must take the data in the cycle it is presented.
// Ports: clk_i, rst_ni (async flush), vld_i/dat_i/lane_i (launch side),
//        vld_o/dat_o (return side; dat_o is zero whenever vld_o is low, disabled lanes zeroed).
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        vld_i,
    input  logic [15:0] dat_i,
    input  logic [1:0]  lane_i,
    output logic        vld_o,
    output logic [15:0] dat_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [15:0]       dat_q  [RD_LAT];
    logic [1:0]        lane_q [RD_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i]  <= '0;
                lane_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= vld_i;
            dat_q[0]  <= dat_i;
            lane_q[0] <= lane_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                dat_q[i]  <= dat_q[i-1];
                lane_q[i] <= lane_q[i-1];
            end
        end
    end

    // Lane masking is applied on the way out so the bus never sees stale bytes
    assign vld_o = vld_q[RD_LAT-1];
    assign dat_o = vld_o ? (dat_q[RD_LAT-1] & lane_mask(lane_q[RD_LAT-1])) : 16'h0000;

endmodule

// File: rtl/sram16_responder.sv
// On-chip stand-in for the external 16-bit async SRAM seen by the CPU memory bridge.
// Writes land at the accepting edge; reads return RD_LAT cycles after acceptance.
// No backpressure: accesses are ignored (not stalled) until ready; contention is flagged sticky.
// Ports: clk, reset (async active low), adr/data_in/ce_n/we_n/oe_n/ub_n/lb_n (bus in),
//        data_out/data_oe (read return), ready, contention, rd_cnt, wr_cnt (status).
module sram16_responder
    import sram_pkg::*;
#(
    parameter int DEPTH_W        = 12,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] adr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic        ce_n,
    input  logic        we_n,
    input  logic        oe_n,
    input  logic        ub_n,
    input  logic        lb_n,
    output logic        ready,
    output logic        contention,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("sram16_responder: RD_LAT must be within 1..3");
    end

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : DONE;

    logic [15:0] mem [2**DEPTH_W];

    state_e             state_q, state_d;
    logic [DEPTH_W-1:0] clr_ptr_q, clr_ptr_d;
    logic               init_wr;
    logic               ready_q;
    logic               cont_q;
    logic [15:0]        rd_cnt_q, wr_cnt_q;

    logic [DEPTH_W-1:0] idx;
    logic               sel, wr_acc, rd_acc;
    logic               unused_adr;

    // Upper address bits alias onto the implemented array
    assign idx        = adr[DEPTH_W-1:0];
    assign unused_adr = ^adr[19:DEPTH_W];

    assign sel    = ~ce_n & ready_q;
    assign wr_acc = sel & ~we_n;            // write wins over a simultaneous read
    assign rd_acc = sel & ~oe_n & we_n;

    // Init sequencer: sweeps the array with zeros, then parks in DONE
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        init_wr   = 1'b0;
        case (state_q)
            INIT: begin
                init_wr   = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == {DEPTH_W{1'b1}}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RST_STATE;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            // Registered so ready reads 0 during reset even when no clear is run
            ready_q   <= (state_d == DONE);
        end
    end

    // Contention is watched regardless of ready, but only while selected by ce_n
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cont_q   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (~ce_n & ~we_n & ~oe_n) begin
                cont_q <= 1'b1;
            end
            if (rd_acc) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (wr_acc) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    // Array has no reset; init sweep and bus writes never overlap since sel needs ready
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[clr_ptr_q] <= 16'h0000;
        end else if (wr_acc) begin
            if (!lb_n) begin
                mem[idx][LANE_LO_MSB:LANE_LO_LSB] <= data_in[LANE_LO_MSB:LANE_LO_LSB];
            end
            if (!ub_n) begin
                mem[idx][LANE_HI_MSB:LANE_HI_LSB] <= data_in[LANE_HI_MSB:LANE_HI_LSB];
            end
        end
    end

    sram_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i  (clk),
        .rst_ni (reset),
        .vld_i  (rd_acc),
        .dat_i  (mem[idx]),
        .lane_i ({~ub_n, ~lb_n}),
        .vld_o  (data_oe),
        .dat_o  (data_out)
    );

    assign ready      = ready_q;
    assign contention = cont_q;
    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;

endmodule
